// File: rtl/reserve_station_multi.sv
`default_nettype none
// ============================================================================
// Module   : reserve_station_multi
// Purpose  : Arithmetic reservation station. Snoops multiple CDB channels and
//            issues the oldest ready entry to the ALU each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module reserve_station_multi #(
    parameter int DEPTH    = 16,
    parameter int NUM_CDB  = 2,
    parameter int DATA_W   = 32,
    parameter int ROB_ID_W = 4,
    parameter int OPENUM_W = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic                         rollback_signal,
    input  logic                         enable_signal_from_dispatcher,
    input  logic [OPENUM_W-1:0]          openum_from_dispatcher,
    input  logic [ROB_ID_W-1:0]          Q1_from_dispatcher,
    input  logic [ROB_ID_W-1:0]          Q2_from_dispatcher,
    input  logic [DATA_W-1:0]            V1_from_dispatcher,
    input  logic [DATA_W-1:0]            V2_from_dispatcher,
    input  logic [DATA_W-1:0]            pc_from_dispatcher,
    input  logic [DATA_W-1:0]            imm_from_dispatcher,
    input  logic [ROB_ID_W-1:0]          rob_id_from_dispatcher,
    output logic                         full_to_dispatcher,
    input  logic [NUM_CDB-1:0]           cdb_valid,
    input  logic [NUM_CDB*ROB_ID_W-1:0]  cdb_rob_id,
    input  logic [NUM_CDB*DATA_W-1:0]    cdb_value,
    output logic                         enable_to_alu,
    output logic [OPENUM_W-1:0]          openum_to_alu,
    output logic [DATA_W-1:0]            V1_to_alu,
    output logic [DATA_W-1:0]            V2_to_alu,
    output logic [DATA_W-1:0]            imm_to_alu,
    output logic [DATA_W-1:0]            pc_to_alu,
    output logic [ROB_ID_W-1:0]          rob_id_to_alu
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]    r_busy;
    logic [OPENUM_W-1:0] r_openum [DEPTH];
    logic [ROB_ID_W-1:0] r_q1     [DEPTH];
    logic [ROB_ID_W-1:0] r_q2     [DEPTH];
    logic [ROB_ID_W-1:0] r_rob    [DEPTH];
    logic [DATA_W-1:0]   r_v1     [DEPTH];
    logic [DATA_W-1:0]   r_v2     [DEPTH];
    logic [DATA_W-1:0]   r_pc     [DEPTH];
    logic [DATA_W-1:0]   r_imm    [DEPTH];
    // r_age[i][j] set means entry i was allocated before entry j
    logic [DEPTH-1:0]    r_age    [DEPTH];

    logic [DEPTH-1:0]    w_ready;
    logic [DEPTH-1:0]    w_col    [DEPTH];
    logic [DEPTH-1:0]    w_sel;
    logic [IDX_W-1:0]    w_issue_idx;
    logic [IDX_W-1:0]    w_free_idx;
    logic                w_full;
    logic [DATA_W:0]     w_disp_s1;
    logic [DATA_W:0]     w_disp_s2;

    // Returns {hit, value}; iterating high-to-low lets the lowest channel win.
    function automatic logic [DATA_W:0] snoop(
        input logic [ROB_ID_W-1:0]         tag,
        input logic [NUM_CDB-1:0]          vld,
        input logic [NUM_CDB*ROB_ID_W-1:0] ids,
        input logic [NUM_CDB*DATA_W-1:0]   vals
    );
        logic [DATA_W:0] res;
        res = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (vld[k] && (tag != '0) && (ids[k*ROB_ID_W +: ROB_ID_W] == tag)) begin
                res = {1'b1, vals[k*DATA_W +: DATA_W]};
            end
        end
        return res;
    endfunction

    always_comb begin
        w_ready = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_ready[i] = r_busy[i] && (r_q1[i] == '0) && (r_q2[i] == '0);
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_col[i] = '0;
            for (int j = 0; j < DEPTH; j++) begin
                w_col[i][j] = r_age[j][i];
            end
        end
    end

    // An entry is the oldest ready one when no other ready entry predates it.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_sel[i] = w_ready[i] && !(|(w_ready & w_col[i]));
        end
    end

    always_comb begin
        w_issue_idx = '0;
        w_free_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_sel[i]) begin
                w_issue_idx = IDX_W'(i);
            end
            if (!r_busy[i]) begin
                w_free_idx = IDX_W'(i);
            end
        end
    end

    assign w_full             = &r_busy;
    assign full_to_dispatcher = w_full;

    assign w_disp_s1 = snoop(Q1_from_dispatcher, cdb_valid, cdb_rob_id, cdb_value);
    assign w_disp_s2 = snoop(Q2_from_dispatcher, cdb_valid, cdb_rob_id, cdb_value);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy        <= '0;
            enable_to_alu <= 1'b0;
            openum_to_alu <= '0;
            V1_to_alu     <= '0;
            V2_to_alu     <= '0;
            imm_to_alu    <= '0;
            pc_to_alu     <= '0;
            rob_id_to_alu <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_age[i]    <= '0;
                r_openum[i] <= '0;
                r_q1[i]     <= '0;
                r_q2[i]     <= '0;
                r_rob[i]    <= '0;
                r_v1[i]     <= '0;
                r_v2[i]     <= '0;
                r_pc[i]     <= '0;
                r_imm[i]    <= '0;
            end
        end else if (rdy) begin
            if (rollback_signal) begin
                r_busy        <= '0;
                enable_to_alu <= 1'b0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    logic [DATA_W:0] s1;
                    logic [DATA_W:0] s2;
                    s1 = snoop(r_q1[i], cdb_valid, cdb_rob_id, cdb_value);
                    s2 = snoop(r_q2[i], cdb_valid, cdb_rob_id, cdb_value);
                    if (r_busy[i] && s1[DATA_W]) begin
                        r_v1[i] <= s1[DATA_W-1:0];
                        r_q1[i] <= '0;
                    end
                    if (r_busy[i] && s2[DATA_W]) begin
                        r_v2[i] <= s2[DATA_W-1:0];
                        r_q2[i] <= '0;
                    end
                end

                if (|w_ready) begin
                    enable_to_alu         <= 1'b1;
                    openum_to_alu         <= r_openum[w_issue_idx];
                    V1_to_alu             <= r_v1[w_issue_idx];
                    V2_to_alu             <= r_v2[w_issue_idx];
                    imm_to_alu            <= r_imm[w_issue_idx];
                    pc_to_alu             <= r_pc[w_issue_idx];
                    rob_id_to_alu         <= r_rob[w_issue_idx];
                    r_busy[w_issue_idx]   <= 1'b0;
                end else begin
                    enable_to_alu <= 1'b0;
                end

                // The free slot is never the issuing slot, so both updates coexist.
                if (enable_signal_from_dispatcher && !w_full) begin
                    r_busy[w_free_idx]   <= 1'b1;
                    r_openum[w_free_idx] <= openum_from_dispatcher;
                    r_pc[w_free_idx]     <= pc_from_dispatcher;
                    r_imm[w_free_idx]    <= imm_from_dispatcher;
                    r_rob[w_free_idx]    <= rob_id_from_dispatcher;
                    if (w_disp_s1[DATA_W]) begin
                        r_q1[w_free_idx] <= '0;
                        r_v1[w_free_idx] <= w_disp_s1[DATA_W-1:0];
                    end else begin
                        r_q1[w_free_idx] <= Q1_from_dispatcher;
                        r_v1[w_free_idx] <= V1_from_dispatcher;
                    end
                    if (w_disp_s2[DATA_W]) begin
                        r_q2[w_free_idx] <= '0;
                        r_v2[w_free_idx] <= w_disp_s2[DATA_W-1:0];
                    end else begin
                        r_q2[w_free_idx] <= Q2_from_dispatcher;
                        r_v2[w_free_idx] <= V2_from_dispatcher;
                    end
                    r_age[w_free_idx] <= '0;
                    for (int j = 0; j < DEPTH; j++) begin
                        r_age[j][w_free_idx] <= r_busy[j];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reserve_station_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_reserve_station_multi
// Purpose  : Directed self-checking bench for reserve_station_multi.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reserve_station_multi;

    localparam int DEPTH    = 16;
    localparam int NUM_CDB  = 2;
    localparam int DATA_W   = 32;
    localparam int ROB_ID_W = 4;
    localparam int OPENUM_W = 6;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        rdy;
    logic                        rollback_signal;
    logic                        en_disp;
    logic [OPENUM_W-1:0]         op_disp;
    logic [ROB_ID_W-1:0]         q1_disp, q2_disp, rob_disp;
    logic [DATA_W-1:0]           v1_disp, v2_disp, pc_disp, imm_disp;
    logic                        full;
    logic [NUM_CDB-1:0]          cdb_valid;
    logic [NUM_CDB*ROB_ID_W-1:0] cdb_rob_id;
    logic [NUM_CDB*DATA_W-1:0]   cdb_value;
    logic                        en_alu;
    logic [OPENUM_W-1:0]         op_alu;
    logic [DATA_W-1:0]           v1_alu, v2_alu, imm_alu, pc_alu;
    logic [ROB_ID_W-1:0]         rob_alu;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reserve_station_multi #(
        .DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .DATA_W(DATA_W),
        .ROB_ID_W(ROB_ID_W), .OPENUM_W(OPENUM_W)
    ) dut (
        .clk                           (clk),
        .rst                           (rst),
        .rdy                           (rdy),
        .rollback_signal               (rollback_signal),
        .enable_signal_from_dispatcher (en_disp),
        .openum_from_dispatcher        (op_disp),
        .Q1_from_dispatcher            (q1_disp),
        .Q2_from_dispatcher            (q2_disp),
        .V1_from_dispatcher            (v1_disp),
        .V2_from_dispatcher            (v2_disp),
        .pc_from_dispatcher            (pc_disp),
        .imm_from_dispatcher           (imm_disp),
        .rob_id_from_dispatcher        (rob_disp),
        .full_to_dispatcher            (full),
        .cdb_valid                     (cdb_valid),
        .cdb_rob_id                    (cdb_rob_id),
        .cdb_value                     (cdb_value),
        .enable_to_alu                 (en_alu),
        .openum_to_alu                 (op_alu),
        .V1_to_alu                     (v1_alu),
        .V2_to_alu                     (v2_alu),
        .imm_to_alu                    (imm_alu),
        .pc_to_alu                     (pc_alu),
        .rob_id_to_alu                 (rob_alu)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [OPENUM_W-1:0] op, input logic [ROB_ID_W-1:0] q1,
                        input logic [ROB_ID_W-1:0] q2, input logic [DATA_W-1:0] v1,
                        input logic [DATA_W-1:0] v2, input logic [ROB_ID_W-1:0] rob);
        en_disp  = 1'b1;
        op_disp  = op;
        q1_disp  = q1;
        q2_disp  = q2;
        v1_disp  = v1;
        v2_disp  = v2;
        rob_disp = rob;
        pc_disp  = 32'h1000 + 32'(rob);
        imm_disp = 32'h40 + 32'(rob);
    endtask

    task automatic cdb(input int ch, input logic [ROB_ID_W-1:0] tag, input logic [DATA_W-1:0] val);
        cdb_valid[ch] = 1'b1;
        cdb_rob_id[ch*ROB_ID_W +: ROB_ID_W] = tag;
        cdb_value[ch*DATA_W +: DATA_W] = val;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; rollback_signal = 1'b0;
        en_disp = 1'b0; op_disp = '0; q1_disp = '0; q2_disp = '0; rob_disp = '0;
        v1_disp = '0; v2_disp = '0; pc_disp = '0; imm_disp = '0;
        cdb_valid = '0; cdb_rob_id = '0; cdb_value = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("reset_en", 64'(en_alu), 64'd0);
        chk("reset_full", 64'(full), 64'd0);
        chk("reset_v1", 64'(v1_alu), 64'd0);
        chk("reset_rob", 64'(rob_alu), 64'd0);

        // Ready ADD: issue visible two edges after dispatch, one cycle only
        disp(6'd1, 4'd0, 4'd0, 32'd5, 32'd7, 4'd1);
        tick(); en_disp = 1'b0;
        chk("add_en_early", 64'(en_alu), 64'd0);
        tick();
        chk("add_en", 64'(en_alu), 64'd1);
        chk("add_v1", 64'(v1_alu), 64'd5);
        chk("add_v2", 64'(v2_alu), 64'd7);
        chk("add_rob", 64'(rob_alu), 64'd1);
        chk("add_op", 64'(op_alu), 64'd1);
        chk("add_pc", 64'(pc_alu), 64'h1001);
        tick();
        chk("add_en_once", 64'(en_alu), 64'd0);

        // Wait on tag 3, woken by CDB channel 1
        disp(6'd2, 4'd3, 4'd0, 32'd0, 32'd1, 4'd2);
        tick(); en_disp = 1'b0;
        tick();
        chk("wait_no_issue", 64'(en_alu), 64'd0);
        cdb(1, 4'd3, 32'hDEAD);
        tick(); cdb_valid = '0;
        chk("wake_en_early", 64'(en_alu), 64'd0);
        tick();
        chk("wake_en", 64'(en_alu), 64'd1);
        chk("wake_v1", 64'(v1_alu), 64'hDEAD);
        chk("wake_rob", 64'(rob_alu), 64'd2);
        tick();

        // Dispatch coinciding with matching CDB on channel 0
        disp(6'd3, 4'd0, 4'd4, 32'd11, 32'd0, 4'd4);
        cdb(0, 4'd4, 32'd9);
        tick(); en_disp = 1'b0; cdb_valid = '0;
        chk("cap_en_early", 64'(en_alu), 64'd0);
        tick();
        chk("cap_en", 64'(en_alu), 64'd1);
        chk("cap_v1", 64'(v1_alu), 64'd11);
        chk("cap_v2", 64'(v2_alu), 64'd9);
        tick();

        // Fill all entries waiting on tag 5
        for (int i = 0; i < DEPTH; i++) begin
            disp(6'd4, 4'd5, 4'd0, 32'd0, 32'(i), 4'(i));
            tick();
            if (i == DEPTH - 2) chk("full_not_yet", 64'(full), 64'd0);
        end
        chk("full_set", 64'(full), 64'd1);
        disp(6'd5, 4'd0, 4'd0, 32'd1, 32'd2, 4'd15);
        tick(); en_disp = 1'b0;
        tick();
        chk("full_drop_no_issue", 64'(en_alu), 64'd0);
        chk("full_held", 64'(full), 64'd1);
        cdb(0, 4'd5, 32'h55);
        tick(); cdb_valid = '0;
        chk("fill_en_early", 64'(en_alu), 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            chk($sformatf("fill_en_%0d", i), 64'(en_alu), 64'd1);
            chk($sformatf("fill_rob_%0d", i), 64'(rob_alu), 64'(i));
            if (i == 0) begin
                chk("fill_v1", 64'(v1_alu), 64'h55);
                chk("full_drop", 64'(full), 64'd0);
            end
        end
        tick();
        chk("fill_done", 64'(en_alu), 64'd0);

        // Rollback with three waiting entries; dispatch in rollback cycle is discarded
        for (int i = 0; i < 3; i++) begin
            disp(6'd6, 4'd6, 4'd0, 32'd0, 32'd0, 4'(i + 1));
            tick();
        end
        disp(6'd7, 4'd0, 4'd0, 32'd3, 32'd4, 4'd12);
        rollback_signal = 1'b1;
        tick(); rollback_signal = 1'b0; en_disp = 1'b0;
        chk("rb_full", 64'(full), 64'd0);
        chk("rb_en", 64'(en_alu), 64'd0);
        cdb(1, 4'd6, 32'h66);
        tick(); cdb_valid = '0;
        tick();
        chk("rb_no_issue_a", 64'(en_alu), 64'd0);
        tick();
        chk("rb_no_issue_b", 64'(en_alu), 64'd0);
        disp(6'd8, 4'd0, 4'd0, 32'd21, 32'd22, 4'd9);
        tick(); en_disp = 1'b0;
        tick();
        chk("rb_after_en", 64'(en_alu), 64'd1);
        chk("rb_after_rob", 64'(rob_alu), 64'd9);
        tick();
        chk("rb_after_once", 64'(en_alu), 64'd0);

        // Pause with ready entries pending
        for (int i = 1; i <= 3; i++) begin
            disp(6'd9, 4'd0, 4'd0, 32'(i), 32'(i), 4'(i));
            tick();
        end
        chk("pause_pre_rob", 64'(rob_alu), 64'd2);
        disp(6'd9, 4'd0, 4'd0, 32'd7, 32'd7, 4'd7);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("pause_en_%0d", i), 64'(en_alu), 64'd1);
            chk($sformatf("pause_rob_%0d", i), 64'(rob_alu), 64'd2);
        end
        en_disp = 1'b0;
        rdy = 1'b1;
        tick();
        chk("resume_en", 64'(en_alu), 64'd1);
        chk("resume_rob", 64'(rob_alu), 64'd3);
        tick();
        chk("resume_no_dup", 64'(en_alu), 64'd0);
        tick();
        chk("resume_idle", 64'(en_alu), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
